frame_stream_source: RTL

- Transmit end of the pixel-stream interface used by the detection pipeline (`en` / `hsync` / `vsync` / `data`).
- Reads a stored frame from a synchronous-read frame memory in raster order and emits it one pixel per enabled cycle, with row and frame markers.
- Drives the pipeline top level in hardware tests and in the frame-replay bench.

---
 rtl/frame_stream_source.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/frame_stream_source.sv
// frame_stream_source
// Reads a stored frame from a synchronous-read frame memory in raster order and
// streams it out one pixel per enabled cycle, with end-of-row (hsync) and
// end-of-frame (vsync) markers qualified by en.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               begin streaming (looked at in IDLE only)
//   continuous          loop frames; looked at when a frame finishes
//   ready               downstream can take a pixel this cycle
//   mem_rd, mem_addr    frame memory read strobe / linear address y*W+x
//   mem_data            read data, valid the cycle after mem_rd
//   en, hsync, vsync    pixel transfer and its row/frame markers
//   data                pixel {B,G,R}, meaningful when en=1
//   busy                not IDLE
//   frame_done          pulse on the transfer of a frame's last pixel
//   frame_count         frames completed since reset
//
// Pixels come out of a 2-entry buffer fed by the memory read data. The head
// entry is a register, so nothing from mem_data reaches an output
// combinationally. A read is issued only when the buffer can still hold its
// data, which lets ready toggle freely without losing or repeating a pixel.
//
// The read of pixel 0 ("launch") is issued combinationally in the cycle that
// decides to start a frame. This is what allows the first en to appear two
// cycles after start, or two cycles after vsync when there is no gap. In GAP,
// the launch is issued two cycles before the gap ends. This gives exactly
// GAP_CYCLES idle cycles between vsync and the next frame's first en.
module frame_stream_source #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int ADDR_WIDTH   = 19,
  parameter int PIXEL_SIZE   = 24,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  ready,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_data,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  busy,
  output logic                  frame_done,
  output logic [31:0]           frame_count
);

  localparam logic [ADDR_WIDTH:0] NPIX = (ADDR_WIDTH+1)'(FRAME_WIDTH * FRAME_HEIGHT);
  localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   rd_cnt;    // next address to read; NPIX once the frame is fully requested
  logic [31:0]           gap_cnt;
  logic                  rd_pend;   // a read was issued last cycle, data is on mem_data now
  logic [PIXEL_SIZE-1:0] buf_q [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            held;
  logic [XW-1:0]         ex;        // coordinates of the pixel at the buffer head
  logic [YW-1:0]         ey;

  logic out_valid, last_col, last_row, last_xfer, space, launch, run_rd;

  always_comb begin
    out_valid  = (held != 2'd0);
    en         = out_valid & ready;
    last_col   = (ex == XW'(FRAME_WIDTH - 1));
    last_row   = (ey == YW'(FRAME_HEIGHT - 1));
    last_xfer  = en & last_col & last_row;
    hsync      = en & last_col & ~last_row;
    vsync      = last_xfer;
    frame_done = last_xfer;
    data       = buf_q[rd_ptr];
    busy       = (state != IDLE);
    // The entry that leaves this cycle frees its slot for a new read.
    space      = ({1'b0, held} + {2'b0, rd_pend}) < (3'd2 + {2'b0, en});
    // Whenever a launch fires, the buffer is either empty or holds only the
    // vsync pixel that is leaving this cycle, so no space check is needed.
    launch     = ((state == IDLE) & start)
               | ((state == RUN) & last_xfer & continuous & (GAP_CYCLES <= 1))
               | ((state == GAP) & (gap_cnt == 32'(GAP_CYCLES - 2)));
    run_rd     = (state == RUN) & (rd_cnt < NPIX) & space;
    mem_rd     = launch | run_rd;
    mem_addr   = launch ? '0 : rd_cnt[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      gap_cnt     <= '0;
      rd_pend     <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      held        <= 2'd0;
      ex          <= '0;
      ey          <= '0;
      frame_count <= '0;
    end else begin
      rd_pend <= mem_rd;
      if (rd_pend) begin
        buf_q[wr_ptr] <= mem_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (en) rd_ptr <= ~rd_ptr;
      held <= held + {1'b0, rd_pend} - {1'b0, en};

      if (en) begin
        if (last_col) begin
          ex <= '0;
          ey <= last_row ? '0 : ey + YW'(1);
        end else begin
          ex <= ex + XW'(1);
        end
      end

      if (last_xfer) frame_count <= frame_count + 32'd1;

      if (launch)         rd_cnt <= (ADDR_WIDTH+1)'(1);
      else if (run_rd)    rd_cnt <= rd_cnt + (ADDR_WIDTH+1)'(1);
      else if (last_xfer) rd_cnt <= '0;

      case (state)
        IDLE: if (launch) state <= RUN;
        RUN: begin
          if (last_xfer && !launch) begin
            state   <= continuous ? GAP : IDLE;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 32'd1;
          if (launch) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
